muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle multiply/divide responder that owns the HI/LO register pair for the MIPS core.
- The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests through a start/busy/done handshake.
- It reads HI/LO back for MFHI/MFLO.
- It replaces single-cycle 32x32 multiply and divide with iterative shift-add and restoring-division datapaths, one bit per cycle.

Parameters:
XLEN, 32, operand width; HI and LO are each XLEN bits.
CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RST  input  1  reset; asynchronous, active-low (asserted when 0).
start  input  1  request strobe; sampled only in IDLE.
func  input  6  R-format function code: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
rs  input  XLEN  first operand (dividend / multiplicand / MTHI-MTLO source).
rt  input  XLEN  second operand (divisor / multiplier).
busy  output  1  high while an operation is in CALC or FIX.
done  output  1  one-cycle pulse in the cycle after HI/LO are written by an arithmetic operation.
HI  output  XLEN  HI register.
LO  output  XLEN  LO register.

Behaviour:
- Reset (RST=0, any time, including mid-operation):
  - HI=0, LO=0, busy=0, done=0, state=IDLE.
  - All internal accumulators and the counter are cleared.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with MTHI: HI<=rs at that edge. Likewise MTLO: LO<=rs. State stays IDLE, busy stays 0, no done pulse.
  - start=1 with an arithmetic func at edge E0:
    - Latch operand magnitudes (|rs|, |rt| for the signed ops; raw values for the unsigned ops).
    - Latch result sign flags and op type. Set counter=0, busy=1.
    - Go to CALC, except DIV/DIVU with rt==0, which go directly to FIX.
  - start=1 with any other func: ignored.
  - start=0: no change.
- CALC: one iteration per edge, 32 edges (E1..E32), counter increments; after the 32nd iteration go to FIX.
  - Multiply: 64-bit shift-add of the magnitudes.
  - Divide: restoring division of the magnitudes producing a 32-bit quotient and remainder.
- FIX, one edge (E33 for the normal path, E1 for divide-by-zero):
  - Apply sign correction and write HI/LO.
  - busy<=0, done<=1 for exactly one cycle, state<=IDLE.
  - New HI/LO are visible from E33, and done is high for the cycle following E33.
- Arithmetic and width rules:
  - MULT: {HI,LO} = signed 64-bit product; negate the 64-bit magnitude product when the operand signs differ.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, negated if the signs differ. HI = remainder, carrying the sign of the dividend.
  - DIVU: LO = unsigned quotient, HI = unsigned remainder.
  - -2^31 / -1: LO=0x80000000, HI=0 (the magnitude wraps naturally in 32 bits).
  - Divide by zero (DIV or DIVU, rt==0): LO=0xFFFFFFFF, HI=rs, total latency 1 edge to FIX plus the write edge.
- While busy=1:
  - start is ignored for all funcs, including MTHI/MTLO.
  - HI and LO hold their old values until the FIX write.
- done is registered, never combinational from start.
- busy rises on the edge after start is sampled, so back-to-back issue is possible in the cycle after done.

Test Plan:
- Reset mid-operation: RST=0 during CALC of MULT -> HI=LO=0, busy=0, done=0 immediately (asynchronous). After release, a new MULTU 2*3 gives LO=6, HI=0.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high from E1 to E33, HI=0xFFFFFFFF, LO=0xFFFFFFF1, done pulses for exactly one cycle after E33.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. A second start during busy is ignored, verified by unchanged results.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=5, rt=0 -> FIX on E1, LO=0xFFFFFFFF, HI=5, done after E1 (no CALC). DIVU 100/7 -> LO=14, HI=2.
- MTHI rs=0x12345678 then MTLO rs=0x9ABCDEF0 on consecutive cycles -> HI and LO update at their respective edges, busy stays 0, done never pulses.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI/LO register pair.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle, sign fixed up at the end.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [5:0]      func,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam int         PW       = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic            fn_mul, fn_div, fn_signed, fn_arith, rt_zero;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;

  // acc/q form one double-width shift register: {product hi, lo} for multiply,
  // {remainder, dividend->quotient} for divide. opnd_b is multiplicand or divisor.
  logic [XLEN-1:0] acc, q, opnd_b;
  logic [CNT_W-1:0] cnt;
  logic             op_div, neg_q, neg_r, div0;

  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] acc_step, q_step;
  logic [PW-1:0]   prod_mag, prod_fix;
  logic [XLEN-1:0] hi_fix, lo_fix;

  assign fn_mul    = (func == FN_MULT) || (func == FN_MULTU);
  assign fn_div    = (func == FN_DIV)  || (func == FN_DIVU);
  assign fn_signed = (func == FN_MULT) || (func == FN_DIV);
  assign fn_arith  = fn_mul || fn_div;
  assign rt_zero   = (rt == '0);
  assign rs_neg    = fn_signed && rs[XLEN-1];
  assign rt_neg    = fn_signed && rt[XLEN-1];
  assign rs_mag    = rs_neg ? (~rs + XLEN'(1)) : rs;
  assign rt_mag    = rt_neg ? (~rt + XLEN'(1)) : rt;

  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start && fn_arith) state_nxt = (fn_div && rt_zero) ? FIX : CALC;
      end
      CALC: begin
        if (cnt == CNT_W'(XLEN - 1)) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of either algorithm; the restoring divide keeps acc < divisor,
  // so the shifted partial remainder always fits in XLEN+1 bits.
  always_comb begin
    acc_step  = acc;
    q_step    = q;
    mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc, q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    if (op_div) begin
      if (div_diff[XLEN]) begin
        acc_step = div_shift[XLEN-1:0];
        q_step   = {q[XLEN-2:0], 1'b0};
      end else begin
        acc_step = div_diff[XLEN-1:0];
        q_step   = {q[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_step = mul_sum[XLEN:1];
      q_step   = {mul_sum[0], q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod_mag = {acc, q};
    prod_fix = neg_q ? (~prod_mag + PW'(1)) : prod_mag;
    hi_fix   = prod_fix[PW-1:XLEN];
    lo_fix   = prod_fix[XLEN-1:0];
    if (div0) begin
      hi_fix = acc;
      lo_fix = '1;
    end else if (op_div) begin
      lo_fix = neg_q ? (~q + XLEN'(1)) : q;
      hi_fix = neg_r ? (~acc + XLEN'(1)) : acc;
    end
  end

  // On divide-by-zero acc carries the raw dividend straight through to HI.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc    <= '0;
      q      <= '0;
      opnd_b <= '0;
      cnt    <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && fn_arith) begin
            cnt    <= '0;
            op_div <= fn_div;
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= rs_neg;
            div0   <= fn_div && rt_zero;
            if (fn_div) begin
              acc    <= rt_zero ? rs : '0;
              q      <= rs_mag;
              opnd_b <= rt_mag;
            end else begin
              acc    <= '0;
              q      <= rt_mag;
              opnd_b <= rs_mag;
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          q   <= q_step;
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      HI   <= '0;
      LO   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == FIX) begin
        HI   <= hi_fix;
        LO   <= lo_fix;
        done <= 1'b1;
      end else if (state == IDLE && start) begin
        if (func == FN_MTHI) HI <= rs;
        if (func == FN_MTLO) LO <= rs;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit.
// Expected HI/LO pairs are queued at issue and popped when done pulses.
module tb_muldiv_unit;

  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam int         WAIT_MAX = 100;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [5:0]  func;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .start(start),
    .func (func),
    .rs   (rs),
    .rt   (rt),
    .busy (busy),
    .done (done),
    .HI   (HI),
    .LO   (LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural reference using wide native arithmetic
  function automatic exp_t model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r.hi = '0;
    r.lo = '0;
    case (f)
      FN_MULT: begin
        sp = sa * sb;
        r.hi = sp[63:32];
        r.lo = sp[31:0];
      end
      FN_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        r.hi = up[63:32];
        r.lo = up[31:0];
      end
      FN_DIV: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = '1;
        end else begin
          sp = sa / sb;
          r.lo = sp[31:0];
          sp = sa % sb;
          r.hi = sp[31:0];
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = '1;
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Caller is at a falling edge; returns at the falling edge after the sampling edge.
  task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    func  = f;
    rs    = a;
    rt    = b;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < WAIT_MAX) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    checks++; if (HI !== 32'd0)  begin errors++; $display("[TB] FAIL reset_hi: got %h expected %h", HI, 32'd0); end
    checks++; if (LO !== 32'd0)  begin errors++; $display("[TB] FAIL reset_lo: got %h expected %h", LO, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_old;
    int done_cnt;
    lo_old   = LO;
    done_cnt = 0;
    start = 1'b1; func = FN_MTHI; rs = 32'h12345678; rt = 32'd0;
    @(posedge CLK); @(negedge CLK);
    if (done === 1'b1) done_cnt++;
    checks++; if (HI !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected %h", HI, 32'h12345678); end
    checks++; if (LO !== lo_old) begin errors++; $display("[TB] FAIL mthi_lo_hold: got %h expected %h", LO, lo_old); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b expected 0", busy); end
    func = FN_MTLO; rs = 32'h9ABCDEF0;
    @(posedge CLK); @(negedge CLK);
    start = 1'b0;
    if (done === 1'b1) done_cnt++;
    checks++; if (LO !== 32'h9ABCDEF0) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected %h", LO, 32'h9ABCDEF0); end
    checks++; if (HI !== 32'h12345678) begin errors++; $display("[TB] FAIL mtlo_hi_hold: got %h expected %h", HI, 32'h12345678); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mtlo_busy: got %b expected 0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("[TB] FAIL mt_no_done: got %0d pulses expected 0", done_cnt); end
  endtask

  task automatic test_mult();
    exp_t e;
    int cyc, busy_bad;
    bit seen;
    logic [31:0] hi_old, lo_old;
    hi_old = HI;
    lo_old = LO;
    sb_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1});
    drive_start(FN_MULT, 32'hFFFFFFFD, 32'd5);
    cyc = 0; seen = 1'b0; busy_bad = 0;
    while (!seen && cyc < WAIT_MAX) begin
      if (busy !== 1'b1 || HI !== hi_old || LO !== lo_old) busy_bad++;
      @(posedge CLK); @(negedge CLK);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (busy_bad != 0) begin errors++; $display("[TB] FAIL mult_busy_hold: got %0d bad cycles expected 0", busy_bad); end
    checks++; if (!seen || cyc != 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 33", cyc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_busy_end: got %b expected 0", busy); end
    e = sb_q.pop_front();
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL mult_result: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
    @(posedge CLK); @(negedge CLK);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mult_done_width: got %b expected 0", done); end
  endtask

  task automatic test_multu_busy_ignore();
    exp_t e;
    int cyc, late_busy;
    bit seen;
    logic [31:0] lo_old;
    lo_old = LO;
    sb_q.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001});
    drive_start(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < WAIT_MAX) begin
      if (cyc == 5) begin start = 1'b1; func = FN_MULT; rs = 32'd1; rt = 32'd1; end
      else if (cyc == 10) begin start = 1'b1; func = FN_MTLO; rs = 32'h11111111; end
      else start = 1'b0;
      @(posedge CLK); @(negedge CLK);
      cyc++;
      if (cyc == 11) begin
        checks++; if (LO !== lo_old) begin errors++; $display("[TB] FAIL busy_mtlo_ignored: got %h expected %h", LO, lo_old); end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    checks++; if (!seen || cyc != 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 33", cyc); end
    e = sb_q.pop_front();
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL multu_result: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
    late_busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); @(negedge CLK);
      if (busy !== 1'b0 || done !== 1'b0) late_busy++;
    end
    checks++; if (late_busy != 0) begin errors++; $display("[TB] FAIL busy_start_ignored: got %0d active cycles expected 0", late_busy); end
  endtask

  task automatic test_div();
    logic [31:0] a_tab [2];
    logic [31:0] b_tab [2];
    logic [31:0] hi_tab[2];
    logic [31:0] lo_tab[2];
    exp_t e;
    int cyc;
    bit seen;
    a_tab = '{32'hFFFFFFF9, 32'h80000000};
    b_tab = '{32'd2,        32'hFFFFFFFF};
    hi_tab = '{32'hFFFFFFFF, 32'h00000000};
    lo_tab = '{32'hFFFFFFFD, 32'h80000000};
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{hi: hi_tab[i], lo: lo_tab[i]});
      drive_start(FN_DIV, a_tab[i], b_tab[i]);
      wait_done(cyc, seen);
      checks++; if (!seen || cyc != 33) begin errors++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 33", i, cyc); end
      e = sb_q.pop_front();
      checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL div_result[%0d]: got %h_%h expected %h_%h", i, HI, LO, e.hi, e.lo); end
    end
  endtask

  task automatic test_divu();
    exp_t e;
    int cyc;
    bit seen;
    sb_q.push_back('{hi: 32'd5, lo: 32'hFFFFFFFF});
    drive_start(FN_DIVU, 32'd5, 32'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL div0_busy: got %b expected 1", busy); end
    wait_done(cyc, seen);
    checks++; if (!seen || cyc != 1) begin errors++; $display("[TB] FAIL div0_latency: got %0d expected 1", cyc); end
    e = sb_q.pop_front();
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL div0_result: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
    sb_q.push_back('{hi: 32'd2, lo: 32'd14});
    drive_start(FN_DIVU, 32'd100, 32'd7);
    wait_done(cyc, seen);
    checks++; if (!seen || cyc != 33) begin errors++; $display("[TB] FAIL divu_latency: got %0d expected 33", cyc); end
    e = sb_q.pop_front();
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL divu_result: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    bit seen;
    sb_q.push_back('{hi: 32'd2, lo: 32'd14});
    drive_start(FN_DIVU, 32'd100, 32'd7);
    wait_done(cyc, seen);
    e = sb_q.pop_front();
    checks++; if (!seen || {HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL b2b_first: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
    sb_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
    drive_start(FN_DIV, 32'hFFFFFFF9, 32'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got busy %b expected 1", busy); end
    wait_done(cyc, seen);
    checks++; if (!seen || cyc != 33) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 33", cyc); end
    e = sb_q.pop_front();
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL b2b_second: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
  endtask

  task automatic test_random();
    logic [5:0] f_tab[4];
    logic [5:0] f;
    logic [31:0] a, b;
    exp_t e;
    int cyc, lat;
    bit seen;
    f_tab = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    for (int i = 0; i < 12; i++) begin
      f = f_tab[i % 4];
      a = $urandom;
      case (i % 3)
        0: b = $urandom;
        1: b = $urandom_range(1, 15) | ((i % 2 == 1) ? 32'hFFFFFFF0 : 32'd0);
        default: b = 32'd0;
      endcase
      lat = ((f == FN_DIV || f == FN_DIVU) && b == 32'd0) ? 1 : 33;
      sb_q.push_back(model_op(f, a, b));
      drive_start(f, a, b);
      wait_done(cyc, seen);
      checks++; if (!seen || cyc != lat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, cyc, lat); end
      e = sb_q.pop_front();
      checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL rand_result[%0d] f=%h a=%h b=%h: got %h_%h expected %h_%h", i, f, a, b, HI, LO, e.hi, e.lo); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int cyc;
    bit seen;
    drive_start(FN_MTHI, 32'hA5A5A5A5, 32'd0);
    drive_start(FN_MTLO, 32'h5A5A5A5A, 32'd0);
    sb_q.push_back(model_op(FN_MULT, 32'd7, 32'd9));
    drive_start(FN_MULT, 32'd7, 32'd9);
    repeat (10) begin @(posedge CLK); @(negedge CLK); end
    #3 RST = 1'b0;
    #1;
    sb_q.delete();
    checks++; if (HI !== 32'd0)  begin errors++; $display("[TB] FAIL midrst_hi: got %h expected %h", HI, 32'd0); end
    checks++; if (LO !== 32'd0)  begin errors++; $display("[TB] FAIL midrst_lo: got %h expected %h", LO, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got %b expected 0", busy); end
    sb_q.push_back('{hi: 32'd0, lo: 32'd6});
    drive_start(FN_MULTU, 32'd2, 32'd3);
    wait_done(cyc, seen);
    checks++; if (!seen || cyc != 33) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 33", cyc); end
    e = sb_q.pop_front();
    checks++; if ({HI, LO} !== {e.hi, e.lo}) begin errors++; $display("[TB] FAIL midrst_result: got %h_%h expected %h_%h", HI, LO, e.hi, e.lo); end
  endtask

  initial begin
    RST   = 1'b0;
    start = 1'b0;
    func  = 6'd0;
    rs    = 32'd0;
    rt    = 32'd0;
    repeat (2) @(negedge CLK);
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu_busy_ignore();
    test_div();
    test_divu();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
